pad_frame_writer: RTL and testbench



---
 rtl/pad_frame_writer.sv | 115 +++++++++++
 tb/tb_pad_frame_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pad_frame_writer.sv
// Writes a raster pixel stream into a zero-bordered (IMG_W+2)x(IMG_H+2) frame memory with a registered read port.
// Optional DROP_DETECT_EN adds a sticky err_drop flag for pixels offered while no frame is being filled.
module pad_frame_writer #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 32,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pixel,
  output logic          busy,
  output logic          frame_done,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
`ifdef DROP_DETECT_EN
  ,
  output logic          err_drop
`endif
);
  localparam int DEPTH = (IMG_W + 2) * (IMG_H + 2);
  localparam int CW    = $clog2(IMG_W + 2);
  localparam int RW    = $clog2(IMG_H + 3);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W + 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   RD_LIMIT  = (AW + 1)'(DEPTH);

  // Handshake: a pixel transfers on a rising clk edge where in_valid && in_ready;
  // in_ready depends only on state and fill position, never on in_valid.
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          border, wr_en, start_ok;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [DEPTH];

  assign border = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    start_ok  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = FILL;
          start_ok  = 1'b1;
        end
      end
      FILL: begin
        // Border cells are written unconditionally; interior cells wait for a pixel.
        in_ready = !border;
        wr_en    = border || in_valid;
        wr_data  = border ? '0 : in_pixel;
        if (wr_en && (wr_addr == ADDR_LAST)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state == FILL);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_addr <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        wr_addr <= '0;
        col     <= '0;
        row     <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a same-cycle write to rd_addr is seen on the following read.
  always_ff @(posedge clk) begin
    if (!rst_n)                          rd_data <= '0;
    else if ({1'b0, rd_addr} < RD_LIMIT) rd_data <= mem[rd_addr];
    else                                 rd_data <= '0;
  end

`ifdef DROP_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                              err_drop <= 1'b0;
    else if (start_ok)                       err_drop <= 1'b0;
    else if (in_valid && (state != FILL))    err_drop <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_pad_frame_writer.sv
// Directed bench for pad_frame_writer: reset values, full-frame fills, readback table and image scans.
module tb_pad_frame_writer;
  localparam int PW    = 258;
  localparam int DEPTH = 8772;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = '0;
  logic        busy;
  logic        frame_done;
  logic [13:0] rd_addr = '0;
  logic [7:0]  rd_data;
`ifdef DROP_DETECT_EN
  logic        err_drop;
`endif

  int total = 0;
  int bad   = 0;

  pad_frame_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .busy(busy), .frame_done(frame_done), .rd_addr(rd_addr),
    .rd_data(rd_data)
`ifdef DROP_DETECT_EN
    , .err_drop(err_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } rd_vec_t;

  rd_vec_t rd_tab[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: pixel index mod 256 (row-independent since the width is 256); mode 1: constant 0xAA
  function automatic logic [7:0] exp_pix(input int mode, input int a);
    int r, c;
    r = a / PW;
    c = a % PW;
    if (a >= DEPTH || r == 0 || r == 33 || c == 0 || c == 257) return 8'h00;
    if (mode == 0) return 8'(c - 1);
    return 8'hAA;
  endfunction

  task automatic fill_frame(input int mode, input bit toggle, input bit rbw,
                            output int cycles, output int stalls, output int idx);
    int  budget;
    bit  v;
    v = 1'b0;
    budget = 0;
    cycles = 0;
    stalls = 0;
    idx = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (busy && budget < 20000) begin
      cycles++;
      budget++;
      v = toggle ? ~v : 1'b1;
      in_valid = v;
      in_pixel = (mode == 0) ? idx[7:0] : 8'hAA;
      if (in_ready && !v) stalls++;
      if (in_ready && v) idx++;
      if (rbw && cycles == 262) check("read_before_write", rd_data, 8'h01);
      if (rbw && cycles == 261) rd_addr = 14'd260;
      step();
    end
    in_valid = 1'b0;
    if (budget >= 20000) check("fill_timeout", 32'd1, 32'd0);
  endtask

  task automatic scan(input string name, input int mode);
    int nbad;
    logic [7:0] e;
    nbad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = a[13:0];
      step();
      e = exp_pix(mode, a);
      if (rd_data !== e) begin
        if (nbad == 0) $display("%s first diff at addr %0d: got %0h expected %0h", name, a, rd_data, e);
        nbad++;
      end
    end
    check(name, nbad, 0);
  endtask

  initial begin
    int cyc, stl, idx, budget;

    rd_tab[0]  = '{14'd0,    8'h00};
    rd_tab[1]  = '{14'd257,  8'h00};
    rd_tab[2]  = '{14'd258,  8'h00};
    rd_tab[3]  = '{14'd259,  8'h00};
    rd_tab[4]  = '{14'd260,  8'h01};
    rd_tab[5]  = '{14'd514,  8'hFF};
    rd_tab[6]  = '{14'd515,  8'h00};
    rd_tab[7]  = '{14'd516,  8'h00};
    rd_tab[8]  = '{14'd517,  8'h00};
    rd_tab[9]  = '{14'd518,  8'h01};
    rd_tab[10] = '{14'd8512, 8'hFF};
    rd_tab[11] = '{14'd8514, 8'h00};
    rd_tab[12] = '{14'd8771, 8'h00};
    rd_tab[13] = '{14'd9000, 8'h00};
    rd_tab[14] = '{14'd16383, 8'h00};
    rd_tab[15] = '{14'd400,  8'h8D};

    // Reset with a pixel offered
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    step();
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);
    in_valid = 1'b0;

    // Frame 1: continuous stream
    fill_frame(0, 1'b0, 1'b0, cyc, stl, idx);
    check("f1_cycles", cyc, DEPTH);
    check("f1_pixels", idx, 8192);
    check("f1_frame_done", frame_done, 1);
    check("f1_busy", busy, 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = rd_tab[i].addr;
      step();
      check($sformatf("rd_tab[%0d] addr %0d", i, rd_tab[i].addr), rd_data, rd_tab[i].data);
    end
    scan("f1_image", 0);

    // Frame 2: in_valid toggling, same image expected
    fill_frame(0, 1'b1, 1'b0, cyc, stl, idx);
    check("f2_cycles", cyc, DEPTH + stl);
    check("f2_pixels", idx, 8192);
    check("f2_frame_done", frame_done, 1);
    scan("f2_image", 0);

    // Partial fill, then reset mid-FILL
    start = 1'b1;
    step();
    start = 1'b0;
    idx = 0;
    budget = 0;
    while (idx < 1000 && budget < 5000) begin
      in_valid = 1'b1;
      in_pixel = idx[7:0];
      if (in_ready) idx++;
      step();
      budget++;
    end
    check("partial_pixels", idx, 1000);
    check("partial_busy", busy, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_in_ready", in_ready, 0);

    // Frame 3: constant 0xAA with a read-before-write probe
    fill_frame(1, 1'b0, 1'b1, cyc, stl, idx);
    check("f3_cycles", cyc, DEPTH);
    check("f3_frame_done", frame_done, 1);
    scan("f3_image", 1);

    // DONE: back-to-back reads, then restart
    rd_addr = 14'd259;
    step();
    check("done_rd_259", rd_data, 8'hAA);
    rd_addr = 14'd9000;
    step();
    check("done_rd_9000", rd_data, 8'h00);
    in_valid = 1'b1;
    step();
    check("done_in_ready", in_ready, 0);
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_frame_done", frame_done, 0);

`ifdef DROP_DETECT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("drop_rst", err_drop, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("drop_set", err_drop, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("drop_clear_on_start", err_drop, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
